// File: rtl/ms_sched_pkg.sv
// Shared types and helpers for the multi-stream pick scheduler.
// Holds the FSM state encoding, an elaboration-time clog2 and the round-robin pointer advance.
package ms_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } sched_state_t;

  // Index width for a stream count; never narrower than one bit.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

  function automatic int rr_next(input int idx, input int flux);
    return (idx >= flux - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ms_rr_arbiter.sv
// Combinational round-robin search: first asserted request at or after rr_ptr, wrapping modulo FLUX.
module ms_rr_arbiter
  import ms_sched_pkg::*;
#(
  parameter int FLUX = 2,
  parameter int IDXW = clog2(FLUX)
) (
  input  logic [FLUX-1:0] req,
  input  logic [IDXW-1:0] rr_ptr,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_any
);

  localparam logic [IDXW:0] FLUX_W = (IDXW + 1)'(FLUX);

  always_comb begin
    logic [IDXW:0] idx;
    idx     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < FLUX; k++) begin
      idx = {1'b0, rr_ptr} + (IDXW + 1)'(k);
      if (idx >= FLUX_W) begin
        idx = idx - FLUX_W;
      end
      if (!gnt_any && req[idx[IDXW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = idx[IDXW-1:0];
      end
    end
  end

endmodule

// File: rtl/ms_pick_scheduler.sv
// Read-side scheduler sharing one FIFO read port among FLUX streams with round-robin bursts.
// Optional per-stream forwarded-token counters are enabled with `MS_SCHED_STATS_EN.
module ms_pick_scheduler
  import ms_sched_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int FLUX  = 2,
`ifdef MS_SCHED_STATS_EN
  parameter int CW    = 16,
`endif
  parameter int BW    = 4,
  localparam int IDXW = clog2(FLUX)
) (
  input  logic             ck,
  input  logic             rst,
  input  logic [FLUX-1:0]  fifo_empty,
  output logic [FLUX-1:0]  fifo_rd,
  input  logic [WIDTH-1:0] fifo_data,
  input  logic [BW-1:0]    burst_len,
  output logic             out_wr,
  output logic [WIDTH-1:0] out_data,
  output logic [IDXW-1:0]  out_flux,
  input  logic             out_full,
  output logic             busy
`ifdef MS_SCHED_STATS_EN
  ,
  output logic [FLUX*CW-1:0] tok_cnt
`endif
);

  sched_state_t    state;
  sched_state_t    state_nxt;
  logic [IDXW-1:0] rr_ptr;
  logic [IDXW-1:0] gnt_q;
  logic [IDXW-1:0] arb_idx;
  logic            arb_any;
  logic [BW-1:0]   limit_q;
  logic [BW-1:0]   cnt;
  logic            out_valid;
  logic            sel_empty;
  logic            rd_en;
  logic            last_rd;

  ms_rr_arbiter #(
    .FLUX (FLUX),
    .IDXW (IDXW)
  ) u_arb (
    .req     (~fifo_empty),
    .rr_ptr  (rr_ptr),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  // A read needs data in the granted stream and room in the output register (or a drain this cycle).
  assign sel_empty = fifo_empty[gnt_q];
  assign rd_en     = (state == GRANT) && !sel_empty && (!out_valid || !out_full);
  assign last_rd   = rd_en && ((cnt + BW'(1)) == limit_q);

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arb_any) state_nxt = GRANT;
      GRANT:   if (last_rd || sel_empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fifo_rd = '0;
    if (rd_en) begin
      fifo_rd[gnt_q] = 1'b1;
    end
    busy   = (state == GRANT);
    out_wr = out_valid && !out_full;
  end

  // Grant bookkeeping: index and burst limit latched on entry, counted only on real reads.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      rr_ptr  <= '0;
      gnt_q   <= '0;
      limit_q <= '0;
      cnt     <= '0;
    end else if (state == IDLE) begin
      if (arb_any) begin
        gnt_q   <= arb_idx;
        limit_q <= (burst_len == '0) ? BW'(1) : burst_len;
        cnt     <= '0;
      end
    end else begin
      if (last_rd || sel_empty) begin
        rr_ptr <= IDXW'(rr_next(int'(gnt_q), FLUX));
        cnt    <= '0;
      end else if (rd_en) begin
        cnt <= cnt + BW'(1);
      end
    end
  end

  // A capture in the same cycle as a drain overwrites the register and keeps it valid.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_flux  <= '0;
    end else if (rd_en) begin
      out_valid <= 1'b1;
      out_data  <= fifo_data;
      out_flux  <= gnt_q;
    end else if (out_wr) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MS_SCHED_STATS_EN
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      tok_cnt <= '0;
    end else begin
      for (int i = 0; i < FLUX; i++) begin
        if (out_wr && (out_flux == IDXW'(i))) begin
          tok_cnt[i*CW +: CW] <= tok_cnt[i*CW +: CW] + CW'(1);
        end
      end
    end
  end
`endif

endmodule
